// File: rtl/dsc_pkg.sv
// Shared constants for the dual-slope phase sequencer: state codes, default counter
// width and the analog switch-select encoding.
`timescale 1ns/1ps
package dsc_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef logic [2:0] dsc_state_t;

  localparam dsc_state_t StIdle  = 3'd0;
  localparam dsc_state_t StAz    = 3'd1;
  localparam dsc_state_t StInt   = 3'd2;
  localparam dsc_state_t StDeint = 3'd3;
  localparam dsc_state_t StDone  = 3'd4;

  // Switch selects packed as {vref, vin, zero}; exactly one bit is ever set.
  typedef logic [2:0] sw_sel_t;

  localparam sw_sel_t SwZero = 3'b001;
  localparam sw_sel_t SwVin  = 3'b010;
  localparam sw_sel_t SwVref = 3'b100;

  function automatic sw_sel_t state_sw(input dsc_state_t st);
    sw_sel_t sel;
    case (st)
      StInt:   sel = SwVin;
      StDeint: sel = SwVref;
      default: sel = SwZero;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
`timescale 1ns/1ps
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC phase sequencer: auto-zero, fixed integrate, timed de-integrate.
// Define DSC_AUTOZERO_EN to insert the AZ_CYCLES-long auto-zero phase before integrate.
`timescale 1ns/1ps
module dual_slope_ctrl
  import dsc_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned N_INT     = 1000,
  parameter int unsigned MAX_DEINT = 2000,
  parameter int unsigned AZ_CYCLES = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic             sw_zero_o,
  output logic             sw_vin_o,
  output logic             sw_vref_o,
  output logic             ref_neg_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] result_o,
  output logic             sign_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] IntLast   = CNT_W'(N_INT - 1);
  localparam logic [CNT_W-1:0] DeintLast = CNT_W'(MAX_DEINT - 1);
  localparam logic [CNT_W-1:0] DeintMax  = CNT_W'(MAX_DEINT);
`ifdef DSC_AUTOZERO_EN
  localparam logic [CNT_W-1:0] AzLast    = CNT_W'(AZ_CYCLES - 1);
`endif

  dsc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  // Comparator level at the end of integrate; de-integrate ends when it changes.
  logic             pol_q, pol_d;
  logic             cmp_s;
  sw_sel_t          sw_sel;

  sync2 u_cmp_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (cmp_i),
    .q_o    (cmp_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    result_d = result_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    pol_d    = pol_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_i) begin
          result_d = '0;
          sign_d   = 1'b0;
          ovf_d    = 1'b0;
`ifdef DSC_AUTOZERO_EN
          state_d  = StAz;
`else
          state_d  = StInt;
`endif
        end
      end
`ifdef DSC_AUTOZERO_EN
      StAz: begin
        if (cnt_q == AzLast) state_d = StInt;
      end
`endif
      StInt: begin
        if (cnt_q == IntLast) begin
          pol_d   = cmp_s;
          state_d = StDeint;
        end
      end
      StDeint: begin
        // A comparator flip takes priority over a coincident timeout.
        if (cmp_s != pol_q) begin
          result_d = cnt_q;
          sign_d   = ~pol_q;
          ovf_d    = 1'b0;
          state_d  = StDone;
        end else if (cnt_q == DeintLast) begin
          result_d = DeintMax;
          sign_d   = ~pol_q;
          ovf_d    = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pol_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      pol_q    <= pol_d;
    end
  end

  assign sw_sel    = state_sw(state_q);
  assign sw_zero_o = sw_sel[0];
  assign sw_vin_o  = sw_sel[1];
  assign sw_vref_o = sw_sel[2];
  // Reference opposes the integrated charge: comparator high means negative reference.
  assign ref_neg_o = (state_q == StDeint) & pol_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign result_o  = result_q;
  assign sign_o    = sign_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed self-checking bench for dual_slope_ctrl (default N_INT=1000, MAX_DEINT=2000).
`timescale 1ns/1ps
module tb_dual_slope_ctrl;

  localparam int CNT_W     = 16;
  localparam int N_INT     = 1000;
  localparam int MAX_DEINT = 2000;
`ifdef DSC_AUTOZERO_EN
  localparam int AZ = 256;
`else
  localparam int AZ = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic             cmp_i;
  logic             sw_zero_o, sw_vin_o, sw_vref_o, ref_neg_o;
  logic             busy_o, done_o, sign_o, ovf_o;
  logic [CNT_W-1:0] result_o;

  int checks = 0;
  int errors = 0;

  dual_slope_ctrl #(
    .CNT_W     (CNT_W),
    .N_INT     (N_INT),
    .MAX_DEINT (MAX_DEINT),
    .AZ_CYCLES (256)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start_i),
    .cmp_i     (cmp_i),
    .sw_zero_o (sw_zero_o),
    .sw_vin_o  (sw_vin_o),
    .sw_vref_o (sw_vref_o),
    .ref_neg_o (ref_neg_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .sign_o    (sign_o),
    .ovf_o     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one conversion from IDLE and records observations; callers do the comparisons.
  task automatic run_conv(input logic cmp_int, input int flip_at, input bit mid_start,
                          output int first_vin, output int vin_cycles, output int zero_cycles,
                          output int overlap, output int done_cyc, output int ref_bad,
                          output int done_cnt, output int idle_busy,
                          output logic [CNT_W-1:0] res, output logic sgn, output logic ovf,
                          output logic busy_after);
    first_vin = -1; vin_cycles = 0; zero_cycles = 0; overlap = 0;
    done_cyc = -1; ref_bad = 0; done_cnt = 0; idle_busy = 0;
    res = 'x; sgn = 1'bx; ovf = 1'bx;
    cmp_i = cmp_int;
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    for (int i = 1; i <= AZ + N_INT; i++) begin
      if ($countones({sw_zero_o, sw_vin_o, sw_vref_o}) != 1) overlap++;
      if (sw_vin_o) begin
        vin_cycles++;
        if (first_vin < 0) first_vin = i;
      end
      if (sw_zero_o) zero_cycles++;
      if (done_o) done_cnt++;
      if (mid_start) start_i = (i == AZ + N_INT / 2);
      next_cycle();
    end
    start_i = 1'b0;
    for (int k = 0; k <= MAX_DEINT + 10; k++) begin
      if ($countones({sw_zero_o, sw_vin_o, sw_vref_o}) != 1) overlap++;
      if (done_o) begin
        done_cyc = k;
        done_cnt++;
        res = result_o;
        sgn = sign_o;
        ovf = ovf_o;
        break;
      end
      if (!sw_vref_o || ref_neg_o !== cmp_int) ref_bad++;
      if (k == flip_at) cmp_i = ~cmp_int;
      next_cycle();
    end
    next_cycle();
    busy_after = busy_o;
    for (int i = 0; i < 20; i++) begin
      if (done_o) done_cnt++;
      if (busy_o) idle_busy++;
      if ($countones({sw_zero_o, sw_vin_o, sw_vref_o}) != 1) overlap++;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    cmp_i = 1'b0;
    repeat (3) next_cycle();
    checks++;
    if ({sw_zero_o, sw_vin_o, sw_vref_o, ref_neg_o, busy_o, done_o, sign_o, ovf_o} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 10000000",
               {sw_zero_o, sw_vin_o, sw_vref_o, ref_neg_o, busy_o, done_o, sign_o, ovf_o});
    end
    checks++;
    if (result_o !== '0) begin
      errors++;
      $display("FAIL reset_result: got %0d expected 0", result_o);
    end
    #3 rst_n = 1'b1;
    repeat (3) next_cycle();
  endtask

  task automatic test_positive();
    int fv, vc, zc, ov, dc, rb, dn, ib;
    logic [CNT_W-1:0] r;
    logic s, o, ba;
    run_conv(1'b1, 500, 1'b0, fv, vc, zc, ov, dc, rb, dn, ib, r, s, o, ba);
    checks++;
    if (fv != AZ + 1) begin errors++; $display("FAIL pos_first_vin: got %0d expected %0d", fv, AZ + 1); end
    checks++;
    if (vc != N_INT) begin errors++; $display("FAIL pos_vin_cycles: got %0d expected %0d", vc, N_INT); end
    checks++;
    if (zc != AZ) begin errors++; $display("FAIL pos_zero_cycles: got %0d expected %0d", zc, AZ); end
    checks++;
    if (dc != 503) begin errors++; $display("FAIL pos_done_cycle: got %0d expected 503", dc); end
    checks++;
    if (r !== 16'd502) begin errors++; $display("FAIL pos_result: got %0d expected 502", r); end
    checks++;
    if (s !== 1'b0 || o !== 1'b0) begin
      errors++; $display("FAIL pos_sign_ovf: got %b%b expected 00", s, o);
    end
    checks++;
    if (rb != 0) begin errors++; $display("FAIL pos_ref_neg: got %0d bad cycles expected 0", rb); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL pos_done_count: got %0d expected 1", dn); end
    checks++;
    if (ov != 0) begin errors++; $display("FAIL pos_switch_overlap: got %0d expected 0", ov); end
    checks++;
    if (ba !== 1'b0 || ib != 0) begin
      errors++; $display("FAIL pos_busy_fall: got %b/%0d expected 0/0", ba, ib);
    end
    checks++;
    if (result_o !== 16'd502) begin
      errors++; $display("FAIL pos_result_held: got %0d expected 502", result_o);
    end
  endtask

  task automatic test_negative();
    int fv, vc, zc, ov, dc, rb, dn, ib;
    logic [CNT_W-1:0] r;
    logic s, o, ba;
    run_conv(1'b0, 123, 1'b0, fv, vc, zc, ov, dc, rb, dn, ib, r, s, o, ba);
    checks++;
    if (r !== 16'd125) begin errors++; $display("FAIL neg_result: got %0d expected 125", r); end
    checks++;
    if (s !== 1'b1 || o !== 1'b0) begin
      errors++; $display("FAIL neg_sign_ovf: got %b%b expected 10", s, o);
    end
    checks++;
    if (rb != 0) begin errors++; $display("FAIL neg_ref_neg: got %0d bad cycles expected 0", rb); end
    checks++;
    if (dn != 1 || ov != 0) begin
      errors++; $display("FAIL neg_done_overlap: got %0d/%0d expected 1/0", dn, ov);
    end
  endtask

  task automatic test_timeout();
    int fv, vc, zc, ov, dc, rb, dn, ib;
    logic [CNT_W-1:0] r;
    logic s, o, ba;
    run_conv(1'b1, -1, 1'b0, fv, vc, zc, ov, dc, rb, dn, ib, r, s, o, ba);
    checks++;
    if (dc != MAX_DEINT) begin
      errors++; $display("FAIL tmo_done_cycle: got %0d expected %0d", dc, MAX_DEINT);
    end
    checks++;
    if (r !== 16'd2000) begin errors++; $display("FAIL tmo_result: got %0d expected 2000", r); end
    checks++;
    if (o !== 1'b1 || s !== 1'b0) begin
      errors++; $display("FAIL tmo_ovf_sign: got %b%b expected 10", o, s);
    end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL tmo_done_count: got %0d expected 1", dn); end
  endtask

  task automatic test_busy_ignore();
    int fv, vc, zc, ov, dc, rb, dn, ib;
    logic [CNT_W-1:0] r;
    logic s, o, ba;
    run_conv(1'b1, 10, 1'b1, fv, vc, zc, ov, dc, rb, dn, ib, r, s, o, ba);
    checks++;
    if (vc != N_INT) begin errors++; $display("FAIL busy_vin_cycles: got %0d expected %0d", vc, N_INT); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", dn); end
    checks++;
    if (r !== 16'd12) begin errors++; $display("FAIL busy_result: got %0d expected 12", r); end
    checks++;
    if (ib != 0) begin errors++; $display("FAIL busy_restart: got %0d busy cycles expected 0", ib); end
  endtask

  task automatic test_back_to_back();
    int w;
    cmp_i = 1'b1;
    start_i = 1'b1;
    w = 0;
    while (!sw_vref_o && w < 3000) begin
      next_cycle();
      w++;
    end
    repeat (3) next_cycle();
    cmp_i = 1'b0;
    w = 0;
    while (!done_o && w < 10) begin
      next_cycle();
      w++;
    end
    checks++;
    if (!done_o || result_o !== 16'd5) begin
      errors++; $display("FAIL b2b_first_result: got done=%b result=%0d expected done=1 result=5",
                         done_o, result_o);
    end
    next_cycle();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy_o); end
    next_cycle();
    checks++;
    if (busy_o !== 1'b1 || (AZ > 0 ? sw_zero_o : sw_vin_o) !== 1'b1 || result_o !== '0) begin
      errors++; $display("FAIL b2b_restart: got busy=%b vin=%b zero=%b result=%0d expected 1 restart and result 0",
                         busy_o, sw_vin_o, sw_zero_o, result_o);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    int dn;
    if (!busy_o) begin
      start_i = 1'b1;
      next_cycle();
      start_i = 1'b0;
    end
    w = 0;
    while (!sw_vref_o && w < 3000) begin
      next_cycle();
      w++;
    end
    repeat (50) next_cycle();
    checks++;
    if (sw_vref_o !== 1'b1) begin errors++; $display("FAIL rst_mid_in_deint: got vref=%b expected 1", sw_vref_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_zero_o, sw_vin_o, sw_vref_o, ref_neg_o, busy_o, done_o, sign_o, ovf_o} !== 8'b1000_0000
        || result_o !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b result=%0d expected 10000000 result=0",
               {sw_zero_o, sw_vin_o, sw_vref_o, ref_neg_o, busy_o, done_o, sign_o, ovf_o}, result_o);
    end
    repeat (2) next_cycle();
    #2 rst_n = 1'b1;
    dn = 0;
    w = 0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      if (done_o) dn++;
      if (busy_o) w++;
    end
    checks++;
    if (dn != 0 || w != 0) begin
      errors++; $display("FAIL rst_mid_after: got done=%0d busy=%0d expected 0/0", dn, w);
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_timeout();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
